// File: rtl/hazard_scheduler_if.sv
// Signal bundle between the pipeline control plane and the hazard scheduler.
// The master drives the pipeline-state inputs; the slave (the scheduler) drives stall/flush/forward controls.
interface hazard_scheduler_if;
  logic [4:0]  RS1_D;
  logic [4:0]  RS2_D;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;
  logic [1:0]  ResultSrcE;
  logic [4:0]  RD_M;
  logic        RegWriteM;
  logic [4:0]  RD_W;
  logic        RegWriteW;
  logic        PCSrcE;
  logic        MulDivStartE;
  logic        MulDivDoneE;
  logic        CntClr;

  logic        StallF;
  logic        StallFD;
  logic        FlushFD;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        MulDivBusy;
  logic        MulDivTimeout;
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;

  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE,
    output RD_M, RegWriteM, RD_W, RegWriteW,
    output PCSrcE, MulDivStartE, MulDivDoneE, CntClr,
    input  StallF, StallFD, FlushFD, StallD, FlushD, FlushE,
    input  ForwardAE, ForwardBE, MulDivBusy, MulDivTimeout, StallCnt, FlushCnt
  );

  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE,
    input  RD_M, RegWriteM, RD_W, RegWriteW,
    input  PCSrcE, MulDivStartE, MulDivDoneE, CntClr,
    output StallF, StallFD, FlushFD, StallD, FlushD, FlushE,
    output ForwardAE, ForwardBE, MulDivBusy, MulDivTimeout, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard scheduler: operand forwarding, load-use interlock, branch flush, multi-cycle
// mul/div stall with watchdog, and saturating stall/flush performance counters.
module hazard_scheduler (
  input  logic              clk,
  input  logic              rst,
  hazard_scheduler_if.slave hz
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      stateQ;
  state_t      stateD;
  logic [5:0]  watchdog;
  logic        timeoutQ;
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  logic        busy;
  logic        ldUse;
  logic        wdExpire;
  logic        branchFlush;
  logic        stallF;
  logic        stallFD;
  logic        flushFD;
  logic        stallD;
  logic        flushD;
  logic        flushE;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Memory stage wins over writeback because it holds the younger result.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       wrM,
    input logic [4:0] rdW,
    input logic       wrW
  );
    if (wrM && (rdM != 5'd0) && (rdM == rs))
      return 2'b10;
    else if (wrW && (rdW != 5'd0) && (rdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.ForwardAE = fwdSel(hz.RS1_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
  assign hz.ForwardBE = fwdSel(hz.RS2_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);

  assign ldUse = (hz.ResultSrcE == 2'b01) && (hz.RD_E != 5'd0) &&
                 ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));

  // A start that completes in the same cycle never occupies the unit.
  assign busy = (stateQ == BUSY) ||
                ((stateQ == IDLE) && hz.MulDivStartE && !hz.MulDivDoneE);

  assign wdExpire = (stateQ == BUSY) && (watchdog == 6'd63) && !hz.MulDivDoneE;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (hz.MulDivStartE && !hz.MulDivDoneE) stateD = BUSY;
      BUSY: if (hz.MulDivDoneE || (watchdog == 6'd63)) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= IDLE;
      watchdog <= 6'd0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if ((stateQ == IDLE) && (stateD == BUSY))
        watchdog <= 6'd0;
      else if (stateQ == BUSY)
        watchdog <= watchdog + 6'd1;
      if (wdExpire)
        timeoutQ <= 1'b1;
    end
  end

  // Priority: multi-cycle busy, then taken branch, then load-use.
  always_comb begin
    stallF      = 1'b0;
    stallFD     = 1'b0;
    flushFD     = 1'b0;
    stallD      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    branchFlush = 1'b0;
    if (busy) begin
      stallF  = 1'b1;
      stallFD = 1'b1;
      stallD  = 1'b1;
      flushE  = 1'b1;
    end else if (hz.PCSrcE) begin
      flushFD     = 1'b1;
      flushD      = 1'b1;
      branchFlush = 1'b1;
    end else if (ldUse) begin
      stallF  = 1'b1;
      stallFD = 1'b1;
      flushD  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= 32'd0;
      flushCnt <= 32'd0;
    end else if (hz.CntClr) begin
      stallCnt <= 32'd0;
      flushCnt <= 32'd0;
    end else begin
      if (stallF)
        stallCnt <= satInc(stallCnt);
      if (branchFlush)
        flushCnt <= satInc(flushCnt);
    end
  end

  assign hz.StallF        = stallF;
  assign hz.StallFD       = stallFD;
  assign hz.FlushFD       = flushFD;
  assign hz.StallD        = stallD;
  assign hz.FlushD        = flushD;
  assign hz.FlushE        = flushE;
  assign hz.MulDivBusy    = busy;
  assign hz.MulDivTimeout = timeoutQ;
  assign hz.StallCnt      = stallCnt;
  assign hz.FlushCnt      = flushCnt;

endmodule
